// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, state type and address-width helper for the register file
package regfile_pkg;

  // Default geometry of the integer register file
  localparam int DEF_W  = 32;
  localparam int DEF_D  = 32;
  localparam int DEF_NR = 2;

  // Controller phases: initialisation sweep, then normal operation
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Address width for a given register count (never narrower than one bit)
  function automatic int aw_of(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// rtl/regfile_init_seq.sv - post-reset sweep sequencer that writes reg[i] = i once
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int D  = DEF_D,
  parameter int AW = aw_of(DEF_D)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_busy,
  output logic          init_we,
  output logic [AW-1:0] init_addr
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;

  // State and sweep counter; reset always restarts the sweep from register 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Advance the sweep one register per cycle; the write of the last register ends it
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_busy = 1'b0;
    init_we   = 1'b0;
    init_addr = cnt;
    case (state)
      S_INIT: begin
        init_busy = 1'b1;
        init_we   = ~rst;
        cnt_nxt   = cnt + AW'(1);
        if (cnt == AW'(D - 1)) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        state_nxt = S_RUN;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with issue/writeback scoreboard (option: REGFILE_BYPASS_EN)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int W  = DEF_W,
  parameter  int D  = DEF_D,
  parameter  int NR = DEF_NR,
  localparam int AW = aw_of(D)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            init_busy,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*W-1:0] rd,
  output logic [NR-1:0]   rbusy,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [W-1:0]    wd,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_a,
  input  logic [AW-1:0]   probe_a,
  output logic [W-1:0]    probe_d
);

  logic [W-1:0]  mem [D];
  logic [D-1:0]  busy;

  logic          init_we;
  logic [AW-1:0] init_addr;

  logic          run;
  logic          wb_hit;
  logic          iss_hit;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  regfile_init_seq #(
    .D  (D),
    .AW (AW)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  assign run     = ~init_busy;
  // Register 0 is hardwired: neither writebacks nor issues ever touch it
  assign wb_hit  = run & we & (wa != '0);
  assign iss_hit = run & iss_v & (iss_a != '0);

  // Single write port shared between the sweep and writeback
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wa;
    wr_data = wd;
    if (init_busy) begin
      wr_en   = init_we;
      wr_addr = init_addr;
      wr_data = W'(init_addr);
    end else begin
      wr_en   = wb_hit & ~rst;
    end
  end

  // Storage array has no reset so it can map onto RAM; the sweep initialises it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Busy bits: writeback clears, issue sets; issue wins on a same-address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (run) begin
      if (wb_hit) begin
        busy[wa] <= 1'b0;
      end
      if (iss_hit) begin
        busy[iss_a] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [W-1:0]  rd_k;
    logic          rb_k;

    assign a = ra[k*AW +: AW];

    // Read port k: registered data and busy bit, optionally bypassed from the writeback
    always_comb begin
      rd_k = '0;
      rb_k = 1'b0;
      if (run) begin
        rd_k = (a == '0) ? '0 : mem[a];
        rb_k = busy[a];
`ifdef REGFILE_BYPASS_EN
        if (wb_hit && (wa == a)) begin
          rd_k = wd;
          rb_k = iss_hit && (iss_a == a);
        end
`endif
      end
    end

    assign rd[k*W +: W] = rd_k;
    assign rbusy[k]     = rb_k;
  end

  // Debug probe reads registered state only
  always_comb begin
    probe_d = '0;
    if (run && (probe_a != '0)) begin
      probe_d = mem[probe_a];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int AW = $clog2(D);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             init_busy;
  logic [NR*AW-1:0] ra;
  logic [NR*W-1:0]  rd;
  logic [NR-1:0]    rbusy;
  logic             we;
  logic [AW-1:0]    wa;
  logic [W-1:0]     wd;
  logic             iss_v;
  logic [AW-1:0]    iss_a;
  logic [AW-1:0]    probe_a;
  logic [W-1:0]     probe_d;

  always #5 clk = ~clk;

  regfile_scoreboard #(.W(W), .D(D), .NR(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .ra        (ra),
    .rd        (rd),
    .rbusy     (rbusy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_v     (iss_v),
    .iss_a     (iss_a),
    .probe_a   (probe_a),
    .probe_d   (probe_d)
  );

  typedef struct {
    int              ph;
    logic            ib;
    logic [NR*W-1:0] rd;
    logic [NR-1:0]   rb;
    logic [W-1:0]    pd;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cur_ph = 0;
  bit         armed  = 1'b0;

  // Reference model: register contents, busy flags, and cycles of sweep left
  logic [W-1:0] m_reg [D];
  bit           m_busy [D];
  int           init_left = 0;

  function automatic string ph_name(input int p);
    case (p)
      1: return "sweep";
      2: return "mid_reset";
      3: return "scoreboard";
      4: return "iss_wb_same";
      5: return "bypass";
      6: return "reg0";
      7: return "random";
      default: return "other";
    endcase
  endfunction

  // One cycle: drive inputs, predict this cycle's outputs, then advance the model at the edge
  task automatic step(input bit r, input bit w_e, input int w_a, input logic [W-1:0] w_d,
                      input bit i_v, input int i_a, input int r0, input int r1, input int p_a);
    exp_t e;
    int   rav [NR];
    rst     = r;
    we      = w_e;
    wa      = AW'(w_a);
    wd      = w_d;
    iss_v   = i_v;
    iss_a   = AW'(i_a);
    rav[0]  = r0;
    rav[1]  = r1;
    ra      = {AW'(r1), AW'(r0)};
    probe_a = AW'(p_a);

    e.ph = cur_ph;
    e.ib = (init_left > 0);
    e.rd = '0;
    e.rb = '0;
    e.pd = '0;
    if (init_left == 0) begin
      for (int k = 0; k < NR; k++) begin
        logic [W-1:0] v;
        logic         b;
        v = (rav[k] == 0) ? '0 : m_reg[rav[k]];
        b = m_busy[rav[k]];
        if (BYP && w_e && (w_a == rav[k]) && (w_a != 0)) begin
          v = w_d;
          b = i_v && (i_a == rav[k]);
        end
        e.rd[k*W +: W] = v;
        e.rb[k]        = b;
      end
      e.pd = (p_a == 0) ? '0 : m_reg[p_a];
    end
    if (armed) q.push_back(e);

    @(posedge clk);
    if (r) begin
      init_left = D;
      for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
      armed = 1'b1;
    end else if (init_left > 0) begin
      m_reg[D - init_left] = W'(D - init_left);
      init_left--;
    end else begin
      if (w_e && (w_a != 0)) begin
        m_reg[w_a]  = w_d;
        m_busy[w_a] = 1'b0;
      end
      if (i_v && (i_a != 0)) m_busy[i_a] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int r0, input int r1);
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, r0, r1, r0);
  endtask

  // Monitor: compare every presented cycle against the oldest prediction
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (init_busy !== e.ib) begin
        errors++;
        $display("FAIL %s init_busy: got %b want %b", ph_name(e.ph), init_busy, e.ib);
      end
      checks++;
      if (rd !== e.rd) begin
        errors++;
        $display("FAIL %s rd: got %h want %h (ra=%h)", ph_name(e.ph), rd, e.rd, ra);
      end
      checks++;
      if (rbusy !== e.rb) begin
        errors++;
        $display("FAIL %s rbusy: got %b want %b (ra=%h)", ph_name(e.ph), rbusy, e.rb, ra);
      end
      checks++;
      if (probe_d !== e.pd) begin
        errors++;
        $display("FAIL %s probe_d: got %h want %h (probe_a=%0d)", ph_name(e.ph), probe_d, e.pd, probe_a);
      end
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_a = '0; ra = '0; probe_a = '0;
    #1;

    // Sweep after a one-cycle reset pulse
    cur_ph = 1;
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 5, 0, 5);
    n = 0;
    while (init_busy && n < 100) begin
      idle(5, 0);
      n++;
    end
    check_int("sweep_len", n, D);
    idle(5, 0);
    idle(0, 5);

    // Reset again ten cycles into a sweep; writes and issues during the sweep are dropped
    cur_ph = 2;
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 3, 3, 3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 3, 32'hDEAD, 1'b1, 3, 3, 3, 3);
    step(1'b1, 1'b1, 3, 32'hDEAD, 1'b1, 3, 3, 3, 3);
    n = 0;
    while (init_busy && n < 100) begin
      step(1'b0, 1'b1, 3, 32'hDEAD, 1'b1, 3, 3, 3, 3);
      n++;
    end
    check_int("mid_reset_len", n, D);
    idle(3, 3);

    // Issue to r7, watch it stay busy, then write it back
    cur_ph = 3;
    step(1'b0, 1'b0, 0, '0, 1'b1, 7, 7, 7, 7);
    for (int i = 0; i < 3; i++) idle(7, 1);
    step(1'b0, 1'b1, 7, 32'h1234, 1'b0, 0, 7, 7, 7);
    idle(7, 7);

    // Issue and writeback to r9 on the same edge
    cur_ph = 4;
    step(1'b0, 1'b1, 9, 32'h5555, 1'b1, 9, 9, 9, 9);
    idle(9, 9);

    // Writeback and read of r4 in the same cycle
    cur_ph = 5;
    step(1'b0, 1'b1, 4, 32'hAAAA, 1'b0, 0, 0, 4, 4);
    idle(0, 4);

    // Register 0 ignores writes and issues
    cur_ph = 6;
    step(1'b0, 1'b1, 0, 32'hFFFF, 1'b1, 0, 0, 0, 0);
    idle(0, 0);

    // Random traffic concentrated on a few registers to provoke hazards
    cur_ph = 7;
    for (int i = 0; i < 800; i++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? D - 1 : 7;
      step(($urandom_range(0, 299) == 0), $urandom_range(0, 1), $urandom_range(0, hi),
           $urandom, $urandom_range(0, 1), $urandom_range(0, hi),
           $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
    end

    @(negedge clk);
    #1;
    check_int("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
